// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply-divide unit.
interface muldiv_unit_if #(
  parameter int unsigned M = 32
);
  logic         start;
  logic [1:0]   op;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         we_hi;
  logic         we_lo;
  logic [M-1:0] wdata;
  logic         busy;
  logic         done;
  logic [M-1:0] hi;
  logic [M-1:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 step per cycle on operand magnitudes, then a single sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned M = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned     CntW    = (M > 1) ? $clog2(M) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(M - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [CntW-1:0] r_cnt;
  logic            r_is_div;
  logic            r_neg_a;
  logic            r_neg_b;
  logic [M-1:0]    r_b;   // multiplicand or divisor magnitude
  logic [M-1:0]    r_ph;  // product high half / partial remainder
  logic [M-1:0]    r_pl;  // multiplier / dividend, shifted out as result bits shift in
  logic [M-1:0]    r_hi;
  logic [M-1:0]    r_lo;
  logic            r_done;

  logic           w_accept;
  logic           w_last;
  logic           w_signed;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [M-1:0]   w_mag_a;
  logic [M-1:0]   w_mag_b;
  logic [M-1:0]   w_mul_addend;
  logic [M:0]     w_mul_sum;
  logic [M:0]     w_div_shift;
  logic           w_div_ge;
  logic [M-1:0]   w_div_diff;
  logic [2*M-1:0] w_prod;
  logic [2*M-1:0] w_prod_fix;
  logic [M-1:0]   w_quot_fix;
  logic [M-1:0]   w_rem_fix;
  logic [M-1:0]   w_res_hi;
  logic [M-1:0]   w_res_lo;

  // Operand conditioning, per-iteration arithmetic and final sign correction
  always_comb begin
    w_accept = (r_state == StIdle) && bus.start;
    w_last   = (r_cnt == LastCnt);
    // op[0] set means unsigned; signed ops work on magnitudes
    w_signed = ~bus.op[0];
    w_a_neg  = w_signed & bus.a[M-1];
    w_b_neg  = w_signed & bus.b[M-1];
    w_mag_a  = w_a_neg ? -bus.a : bus.a;
    w_mag_b  = w_b_neg ? -bus.b : bus.b;

    // Shift-add: add multiplicand when the current multiplier LSB is set
    w_mul_addend = r_pl[0] ? r_b : '0;
    w_mul_sum    = {1'b0, r_ph} + {1'b0, w_mul_addend};

    // Restoring divide: the true difference always fits M bits when it is kept
    w_div_shift = {r_ph, r_pl[M-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    w_div_diff  = w_div_shift[M-1:0] - r_b;

    // A zero divisor makes every trial subtract succeed, so the quotient is all
    // ones and the remainder ends up equal to the dividend magnitude; the normal
    // sign fix then yields HI=a and LO=1/all-ones without a special case.
    w_prod     = {r_ph, r_pl};
    w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    w_quot_fix = (r_neg_a ^ r_neg_b) ? -r_pl : r_pl;
    w_rem_fix  = r_neg_a ? -r_ph : r_ph;

    w_res_hi = r_is_div ? w_rem_fix  : w_prod_fix[2*M-1:M];
    w_res_lo = r_is_div ? w_quot_fix : w_prod_fix[M-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept, M iterations, one fix-up cycle
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StFix;
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: busy follows state, done is the registered fix-up marker
  always_comb begin
    bus.busy = (r_state != StIdle);
    bus.done = r_done;
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

  // Operand latch at accept, then one radix-2 iteration per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b      <= '0;
      r_ph     <= '0;
      r_pl     <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= bus.op[1];
      r_neg_a  <= w_a_neg;
      r_neg_b  <= w_b_neg;
      r_b      <= w_mag_b;
      r_ph     <= '0;
      r_pl     <= w_mag_a;
    end else if (r_state == StRun) begin
      r_cnt <= r_cnt + CntW'(1);
      if (r_is_div) begin
        if (w_div_ge) begin
          r_ph <= w_div_diff;
          r_pl <= {r_pl[M-2:0], 1'b1};
        end else begin
          r_ph <= w_div_shift[M-1:0];
          r_pl <= {r_pl[M-2:0], 1'b0};
        end
      end else begin
        r_ph <= w_mul_sum[M:1];
        r_pl <= {w_mul_sum[0], r_pl[M-1:1]};
      end
    end
  end

  // HI/LO: result write in FIX, direct MTHI/MTLO writes only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == StFix) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (r_state == StIdle) begin
      if (bus.we_hi) r_hi <= bus.wdata;
      if (bus.we_lo) r_lo <= bus.wdata;
    end
  end

  // done pulses for the single cycle after HI/LO take the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == StFix);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, random ops against an
// arithmetic reference model, protocol corner cases and reset behaviour.
module tb_muldiv_unit;
  localparam int unsigned M = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.M(M)) tb_if ();

  muldiv_unit #(.M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tb_if)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  // Reference: plain 64-bit arithmetic plus the architectural zero-divisor rules
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) begin
          res = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h1;
      4:       v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op at the next edge and follow it until done (bounded). Optionally
  // pokes start/we_hi/we_lo mid-flight at cycle poke_at to probe busy-time inputs.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic whi, input logic wlo, input logic [31:0] wd,
                        input int poke_at,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic [31:0] hi0, output logic [31:0] lo0,
                        output int lat, output int busy_cyc, output bit held);
    tb_if.start = 1'b1;
    tb_if.op    = op;
    tb_if.a     = a;
    tb_if.b     = b;
    tb_if.we_hi = whi;
    tb_if.we_lo = wlo;
    tb_if.wdata = wd;
    @(negedge clk);
    // Scramble inputs after accept; the latched operands must be used
    tb_if.start = 1'b0;
    tb_if.we_hi = 1'b0;
    tb_if.we_lo = 1'b0;
    tb_if.op    = 2'($urandom);
    tb_if.a     = $urandom;
    tb_if.b     = $urandom;
    hi0      = tb_if.hi;
    lo0      = tb_if.lo;
    hi       = 32'h0;
    lo       = 32'h0;
    lat      = -1;
    busy_cyc = 0;
    held     = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k == poke_at + 1) begin
        tb_if.start = 1'b0;
        tb_if.we_hi = 1'b0;
        tb_if.we_lo = 1'b0;
      end
      if (tb_if.busy) begin
        busy_cyc++;
        if (tb_if.hi !== hi0 || tb_if.lo !== lo0) held = 1'b0;
      end
      if (tb_if.done) begin
        lat = k;
        hi  = tb_if.hi;
        lo  = tb_if.lo;
        break;
      end
      if (k == poke_at) begin
        tb_if.start = 1'b1;
        tb_if.op    = 2'($urandom);
        tb_if.a     = $urandom;
        tb_if.b     = $urandom;
        tb_if.we_hi = 1'b1;
        tb_if.we_lo = 1'b1;
        tb_if.wdata = 32'h0000_1234;
      end
      @(negedge clk);
    end
    tb_if.start = 1'b0;
    tb_if.we_hi = 1'b0;
    tb_if.we_lo = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo, hi0, lo0;
    int          lat, bc;
    bit          held;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (tb_if.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tb_if.busy);
               else n_pass++;
    n_total++; if (tb_if.done !== 1'b0) $display("FAIL reset_done got %b want 0", tb_if.done);
               else n_pass++;
    n_total++; if (tb_if.hi !== 32'h0) $display("FAIL reset_hi got %h want 0", tb_if.hi);
               else n_pass++;
    n_total++; if (tb_if.lo !== 32'h0) $display("FAIL reset_lo got %h want 0", tb_if.lo);
               else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // First start offered right at release must be taken at the first edge
    run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 32'h0, -10, hi, lo, hi0, lo0, lat, bc, held);
    n_total++; if (lat !== M + 1) $display("FAIL first_start_lat got %0d want %0d", lat, M + 1);
               else n_pass++;
    n_total++; if (lo !== 32'd42) $display("FAIL first_start_lo got %h want 2a", lo);
               else n_pass++;
  endtask

  task automatic test_directed();
    vec_t        v[8];
    logic [31:0] hi, lo, hi0, lo0;
    int          lat, bc;
    bit          held;
    v[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    v[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[4] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    v[5] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001};
    v[6] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    v[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 1'b0, 1'b0, 32'h0, -10, hi, lo, hi0, lo0, lat, bc, held);
      n_total++;
      if (hi !== v[i].hi) $display("FAIL dir%0d_hi got %h want %h", i, hi, v[i].hi);
      else n_pass++;
      n_total++;
      if (lo !== v[i].lo) $display("FAIL dir%0d_lo got %h want %h", i, lo, v[i].lo);
      else n_pass++;
      n_total++;
      if (lat !== M + 1) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, M + 1);
      else n_pass++;
      n_total++;
      if (bc !== M + 1) $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, M + 1);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (tb_if.done !== 1'b0) $display("FAIL dir%0d_done_width got %b want 0", i, tb_if.done);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo, hi0, lo0;
    logic [63:0] exp;
    logic [1:0]  op;
    int          lat, bc;
    bit          held;
    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom);
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_model(op, a, b);
      run_op(op, a, b, 1'b0, 1'b0, 32'h0, -10, hi, lo, hi0, lo0, lat, bc, held);
      n_total++;
      if (hi !== exp[63:32])
        $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, hi, exp[63:32]);
      else n_pass++;
      n_total++;
      if (lo !== exp[31:0])
        $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, lo, exp[31:0]);
      else n_pass++;
      n_total++;
      if (held !== 1'b1) $display("FAIL rnd%0d_hilo_hold got changed want held", i);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] hi, lo, hi0, lo0;
    logic [63:0] exp;
    int          lat, bc, late_busy;
    bit          held;
    exp = ref_model(2'b11, 32'd1000, 32'd7);
    run_op(2'b11, 32'd1000, 32'd7, 1'b0, 1'b0, 32'h0, 10, hi, lo, hi0, lo0, lat, bc, held);
    n_total++; if (lat !== M + 1) $display("FAIL busy_ign_lat got %0d want %0d", lat, M + 1);
               else n_pass++;
    n_total++; if (lo !== exp[31:0]) $display("FAIL busy_ign_lo got %h want %h", lo, exp[31:0]);
               else n_pass++;
    n_total++; if (hi !== exp[63:32]) $display("FAIL busy_ign_hi got %h want %h", hi, exp[63:32]);
               else n_pass++;
    n_total++; if (held !== 1'b1) $display("FAIL busy_write_ignored got changed want held");
               else n_pass++;
    late_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (tb_if.busy) late_busy++;
    end
    n_total++; if (late_busy !== 0) $display("FAIL busy_no_queue got %0d want 0", late_busy);
               else n_pass++;
  endtask

  task automatic test_direct_write();
    logic [31:0] hi_before, w;
    hi_before   = tb_if.hi;
    tb_if.we_lo = 1'b1;
    tb_if.wdata = 32'h0000_1234;
    @(negedge clk);
    tb_if.we_lo = 1'b0;
    n_total++; if (tb_if.lo !== 32'h0000_1234) $display("FAIL mtlo got %h want 1234", tb_if.lo);
               else n_pass++;
    n_total++; if (tb_if.hi !== hi_before) $display("FAIL mtlo_hi got %h want %h", tb_if.hi,
                                                    hi_before);
               else n_pass++;
    w           = $urandom;
    tb_if.we_hi = 1'b1;
    tb_if.we_lo = 1'b1;
    tb_if.wdata = w;
    @(negedge clk);
    tb_if.we_hi = 1'b0;
    tb_if.we_lo = 1'b0;
    tb_if.wdata = ~w;
    @(negedge clk);
    n_total++; if (tb_if.hi !== w) $display("FAIL mthi_both got %h want %h", tb_if.hi, w);
               else n_pass++;
    n_total++; if (tb_if.lo !== w) $display("FAIL mtlo_both got %h want %h", tb_if.lo, w);
               else n_pass++;
  endtask

  task automatic test_write_with_start();
    logic [31:0] hi, lo, hi0, lo0;
    logic [63:0] exp;
    int          lat, bc;
    bit          held;
    exp = ref_model(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
    run_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1'b1, 1'b1, 32'hCAFE_F00D, -10,
           hi, lo, hi0, lo0, lat, bc, held);
    n_total++; if (hi0 !== 32'hCAFE_F00D) $display("FAIL wr_start_hi0 got %h want cafef00d", hi0);
               else n_pass++;
    n_total++; if (lo0 !== 32'hCAFE_F00D) $display("FAIL wr_start_lo0 got %h want cafef00d", lo0);
               else n_pass++;
    n_total++; if (hi !== exp[63:32]) $display("FAIL wr_start_hi got %h want %h", hi, exp[63:32]);
               else n_pass++;
    n_total++; if (lo !== exp[31:0]) $display("FAIL wr_start_lo got %h want %h", lo, exp[31:0]);
               else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo, hi0, lo0;
    int          lat, bc, n_done, n_busy;
    bit          held;
    tb_if.we_hi = 1'b1;
    tb_if.we_lo = 1'b1;
    tb_if.wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    tb_if.we_hi = 1'b0;
    tb_if.we_lo = 1'b0;
    tb_if.start = 1'b1;
    tb_if.op    = 2'b01;
    tb_if.a     = 32'hFFFF_0001;
    tb_if.b     = 32'h0001_FFFF;
    @(negedge clk);
    tb_if.start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (tb_if.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", tb_if.busy);
               else n_pass++;
    n_total++; if (tb_if.done !== 1'b0) $display("FAIL midrst_done got %b want 0", tb_if.done);
               else n_pass++;
    n_total++; if (tb_if.hi !== 32'h0) $display("FAIL midrst_hi got %h want 0", tb_if.hi);
               else n_pass++;
    n_total++; if (tb_if.lo !== 32'h0) $display("FAIL midrst_lo got %h want 0", tb_if.lo);
               else n_pass++;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    n_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (tb_if.done) n_done++;
      if (tb_if.busy) n_busy++;
    end
    n_total++; if (n_done !== 0) $display("FAIL midrst_no_done got %0d want 0", n_done);
               else n_pass++;
    n_total++; if (n_busy !== 0) $display("FAIL midrst_no_busy got %0d want 0", n_busy);
               else n_pass++;
    n_total++; if (tb_if.lo !== 32'h0) $display("FAIL midrst_lo_kept got %h want 0", tb_if.lo);
               else n_pass++;
    run_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0, -10, hi, lo, hi0, lo0, lat, bc, held);
    n_total++; if (lo !== 32'd12) $display("FAIL post_rst_lo got %h want c", lo);
               else n_pass++;
    n_total++; if (hi !== 32'h0) $display("FAIL post_rst_hi got %h want 0", hi);
               else n_pass++;
    n_total++; if (lat !== M + 1) $display("FAIL post_rst_lat got %0d want %0d", lat, M + 1);
               else n_pass++;
  endtask

  initial begin
    tb_if.start = 1'b0;
    tb_if.op    = 2'b00;
    tb_if.a     = 32'h0;
    tb_if.b     = 32'h0;
    tb_if.we_hi = 1'b0;
    tb_if.we_lo = 1'b0;
    tb_if.wdata = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_direct_write();
    test_write_with_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: M, 32, operand and HI/LO width; iteration count equals M.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled at rising edge.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  M  multiplicand or dividend (rs).
REQ-007 b  input  M  multiplier or divisor (rt).
REQ-008 we_hi  input  1  direct HI write (MTHI).
REQ-009 we_lo  input  1  direct LO write (MTLO).
REQ-010 wdata  input  M  data for we_hi/we_lo.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 done  output  1  one-cycle pulse after HI/LO receive a result.
REQ-013 hi  output  M  HI register (product upper half or remainder); feeds the writeback result mux.
REQ-014 lo  output  M  LO register (product lower half or quotient); feeds the writeback result mux.
REQ-015 The block has one clock; reset is asynchronous and active-low.

Function
REQ-016 FSM states: IDLE, RUN, FIX; busy SHALL be high exactly when state is not IDLE.
REQ-017 IDLE: start=1 at an edge -> latch op, a, b; clear iteration counter; go to RUN. This is the accept edge, E0.
REQ-018 RUN: one radix-2 iteration per cycle on operand magnitudes (signed ops) or raw operands (unsigned ops). After M iterations (edge EM) -> FIX.
REQ-019 Multiply: shift-add, 2M-bit result.
REQ-020 Divide: restoring, yielding an M-bit quotient and an M-bit remainder.
REQ-021 FIX: apply sign correction, then write HI/LO at edge E(M+1) and go to IDLE.
REQ-022 done SHALL be high for exactly one cycle following E(M+1).
REQ-023 Latency: result visible on hi/lo M+1 edges after accept; busy high for M+1 cycles.
REQ-024 Signed multiply: negate the 2M-bit product when the operand signs differ.
REQ-025 Signed divide: quotient truncates toward zero; quotient negated if the signs differ; remainder takes the sign of the dividend.
REQ-026 Divide by zero (no exception, same latency):
  - DIVU: HI=a, LO=all ones.
  - DIV: HI=a; LO=1 if a negative, else all ones.
REQ-027 DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-028 Operands are latched at accept; later changes to a, b, op have no effect.
REQ-029 start while busy is ignored; no queuing.
REQ-030 we_hi/we_lo in IDLE write wdata at that edge; both may assert together.
REQ-031 we_hi/we_lo while busy are ignored.
REQ-032 start and we_hi/we_lo in the same IDLE cycle: the direct write occurs, the operation is accepted, and the result later overwrites HI/LO.
REQ-033 hi/lo hold their value between writes; they are not altered during RUN.

Reset
REQ-034 rst_n low forces, immediately and independent of clk: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-035 Reset mid-operation abandons the operation; no done pulse and no HI/LO write follows.
REQ-036 The first start is accepted at the first rising edge with rst_n high.

Verification
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly 33 edges after accept; busy high for 33 cycles.
REQ-038 MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0.
REQ-039 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=2 -> LO=3, HI=1.
REQ-040 Divide-by-zero and overflow cases:
  - DIV a=0xFFFFFFF9, b=0 -> HI=0xFFFFFFF9, LO=1.
  - DIVU a=5, b=0 -> HI=5, LO=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-041 Protocol cases:
  - start pulse at cycle 10 of an op -> ignored; only the first result appears.
  - we_lo=1, wdata=0x1234 while busy -> LO unchanged.
  - we_lo in IDLE -> LO=0x1234 next edge.
REQ-042 Reset cases:
  - rst_n low at RUN iteration 15 -> busy, done, hi, lo read 0 before the next edge; no done pulse afterwards.
  - A new MULTU 3x4 after reset release -> LO=12, HI=0.
